// File: rtl/mul_trans_n_if.sv
// Stream bundle for mul_trans_n: CHL joined input channels, one result stream,
// the combine-mode select and the delivered-result count.
interface mul_trans_n_if #(
  parameter int WD    = 9,
  parameter int CHL   = 2,
  parameter int CNT_W = 16
);
  logic [CHL-1:0]    s_valid;
  logic [CHL*WD-1:0] s_data;
  logic [CHL-1:0]    s_ready;
  logic              mode;
  logic              m_valid;
  logic [WD-1:0]     m_data;
  logic              m_ready;
  logic [CNT_W-1:0]  txn_cnt;

  modport master (
    output s_valid, s_data, mode, m_ready,
    input  s_ready, m_valid, m_data, txn_cnt
  );

  modport slave (
    input  s_valid, s_data, mode, m_ready,
    output s_ready, m_valid, m_data, txn_cnt
  );
endinterface

// File: rtl/mul_trans_n.sv
// N-channel join: per-channel 2-entry FIFOs, product/sum of the heads' payloads
// with a non-zero flag as MSB, a DEPTH-stage back-pressurable pipeline and a delivery count.
module mul_trans_n #(
  parameter int WD    = 9,
  parameter int CHL   = 2,
  parameter int DEPTH = 1,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  mul_trans_n_if.slave  bus
);

  logic [CHL-1:0]           fifo_nempty;
  logic [CHL-1:0]           ready_vec;
  logic [CHL-1:0]           msb_unused;
  logic [CHL-1:0][WD-2:0]   head_pay;
  logic                     join_fire;

  logic [DEPTH-1:0]         stg_valid_reg;
  logic [DEPTH-1:0][WD-1:0] stg_data_reg;
  logic [DEPTH:0]           acc;
  logic [CNT_W-1:0]         txn_cnt_reg;

  logic [WD-2:0]            prod;
  logic [WD-2:0]            sum;
  logic [WD-2:0]            res;
  logic [WD-1:0]            res_word;

  genvar gi;
  generate
    for (gi = 0; gi < CHL; gi++) begin : g_ch
      logic [WD-2:0] mem_reg [2];
      logic          wr_ptr_reg;
      logic          rd_ptr_reg;
      logic [1:0]    count_reg;
      logic [1:0]    count_next;
      logic          ready_reg;
      logic          push;

      assign push = bus.s_valid[gi] & ready_reg;

      always_comb begin
        count_next = count_reg;
        case ({push, join_fire})
          2'b10:   count_next = count_reg + 2'd1;
          2'b01:   count_next = count_reg - 2'd1;
          default: count_next = count_reg;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= 1'b0;
          rd_ptr_reg <= 1'b0;
          count_reg  <= 2'd0;
          ready_reg  <= 1'b1;
        end else begin
          if (push)
            wr_ptr_reg <= ~wr_ptr_reg;
          if (join_fire)
            rd_ptr_reg <= ~rd_ptr_reg;
          count_reg <= count_next;
          // Ready is registered from the post-update occupancy, so a full FIFO never sees a push.
          ready_reg <= (count_next != 2'd2);
        end
      end

      always_ff @(posedge clk) begin
        if (push && !rst)
          mem_reg[wr_ptr_reg] <= bus.s_data[gi*WD +: WD-1];
      end

      // Each channel's MSB carries no payload and is dropped on entry.
      assign msb_unused[gi]  = bus.s_data[gi*WD + WD-1];
      assign fifo_nempty[gi] = (count_reg != 2'd0);
      assign head_pay[gi]    = mem_reg[rd_ptr_reg];
      assign ready_vec[gi]   = ready_reg;
    end
  endgenerate

  assign bus.s_ready = ready_vec;

  always_comb begin
    prod = (WD-1)'(1);
    sum  = '0;
    for (int i = 0; i < CHL; i++) begin
      prod = prod * head_pay[i];
      sum  = sum + head_pay[i];
    end
    res      = bus.mode ? sum : prod;
    res_word = {|res, res};
  end

  // A stage accepts when empty or when the stage after it is accepting.
  always_comb begin
    acc        = '0;
    acc[DEPTH] = bus.m_ready;
    for (int k = DEPTH-1; k >= 0; k--)
      acc[k] = ~stg_valid_reg[k] | acc[k+1];
  end

  assign join_fire = (&fifo_nempty) & acc[0];

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stg
      logic          in_valid;
      logic [WD-1:0] in_data;

      if (gi == 0) begin : g_first
        assign in_valid = join_fire;
        assign in_data  = res_word;
      end else begin : g_next
        assign in_valid = stg_valid_reg[gi-1];
        assign in_data  = stg_data_reg[gi-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          stg_valid_reg[gi] <= 1'b0;
          stg_data_reg[gi]  <= '0;
        end else if (acc[gi]) begin
          stg_valid_reg[gi] <= in_valid;
          if (in_valid)
            stg_data_reg[gi] <= in_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      txn_cnt_reg <= '0;
    else if (stg_valid_reg[DEPTH-1] && bus.m_ready)
      txn_cnt_reg <= txn_cnt_reg + CNT_W'(1);
  end

  assign bus.m_valid = stg_valid_reg[DEPTH-1];
  assign bus.m_data  = stg_data_reg[DEPTH-1];
  assign bus.txn_cnt = txn_cnt_reg;

endmodule

// File: tb/tb_mul_trans_n.sv
// Bench for mul_trans_n (WD=9, CHL=3, DEPTH=2): directed vectors plus a queue-based
// reference model checked on every cycle against the result stream.
module tb_mul_trans_n;
  localparam int WD    = 9;
  localparam int CHL   = 3;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_trans_n_if #(.WD(WD), .CHL(CHL), .CNT_W(CNT_W)) bus ();

  mul_trans_n #(.WD(WD), .CHL(CHL), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Reference: combine payloads with plain integer arithmetic, then reduce modulo 2^(WD-1).
  function automatic logic [WD-1:0] model(input logic [CHL-1:0][WD-1:0] d, input logic m);
    longint unsigned a;
    longint unsigned r;
    r = m ? 0 : 1;
    for (int i = 0; i < CHL; i++) begin
      a = longint'(d[i]) % (longint'(1) << (WD-1));
      r = m ? (r + a) : ((r * a) % (longint'(1) << (WD-1)));
    end
    r = r % (longint'(1) << (WD-1));
    return {(r != 0), r[WD-2:0]};
  endfunction

  // ---------------- cycle monitor ----------------
  logic [WD-1:0] chq [CHL][$];
  logic [WD-1:0] exp_q [$];
  int unsigned   model_cnt;
  logic          stall_prev;
  logic [WD-1:0] stall_data;

  function automatic bit all_ne();
    for (int i = 0; i < CHL; i++)
      if (chq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [CHL-1:0][WD-1:0] h;
    if (rst) begin
      for (int i = 0; i < CHL; i++) chq[i].delete();
      exp_q.delete();
      model_cnt  = 0;
      stall_prev = 1'b0;
    end else begin
      chk("mon_txn_cnt", bus.txn_cnt, model_cnt);
      if (stall_prev) begin
        chk("mon_stall_valid", bus.m_valid, 1);
        chk("mon_stall_data", bus.m_data, stall_data);
      end
      for (int i = 0; i < CHL; i++)
        if (bus.s_valid[i] && bus.s_ready[i])
          chq[i].push_back(bus.s_data[i*WD +: WD]);
      while (all_ne()) begin
        for (int i = 0; i < CHL; i++) h[i] = chq[i].pop_front();
        exp_q.push_back(model(h, bus.mode));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got 0x%0h expected no result", bus.m_data);
        end else begin
          chk("mon_result", bus.m_data, exp_q.pop_front());
        end
        model_cnt++;
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WD-1:0] d0, input logic [WD-1:0] d1, input logic [WD-1:0] d2);
    bus.s_data  = {d2, d1, d0};
    bus.s_valid = '1;
    tick();
    bus.s_valid = '0;
  endtask

  task automatic wait_out(output logic [WD-1:0] d, output int lat);
    lat = 0;
    while (!bus.m_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!bus.m_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_out: got no m_valid in 20 cycles expected a result");
    end
    d = bus.m_data;
  endtask

  initial begin
    logic [WD-1:0] d;
    int lat;
    int acc_cnt [CHL];

    rst         = 1'b1;
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.mode    = 1'b0;
    bus.m_ready = 1'b1;

    chk("model_prod", model({9'h007, 9'h005, 9'h003}, 1'b0), 9'h169);
    chk("model_ovf",  model({9'h002, 9'h010, 9'h110}, 1'b0), 9'h000);
    chk("model_sum",  model({9'd10, 9'd100, 9'd200}, 1'b1), 9'h136);

    tick();
    tick();
    rst = 1'b0;
    chk("rst_s_ready", bus.s_ready, 3'b111);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data",  bus.m_data, 0);
    chk("rst_txn_cnt", bus.txn_cnt, 0);

    // product; m_valid arrives 1+DEPTH cycles after the write cycle, i.e. DEPTH ticks after send
    send(9'h003, 9'h005, 9'h007);
    wait_out(d, lat);
    chk("prod_data", d, 9'h169);
    chk("prod_latency", lat, DEPTH);
    tick();
    chk("prod_txn_cnt", bus.txn_cnt, 1);
    chk("prod_idle", bus.m_valid, 0);

    send(9'h110, 9'h010, 9'h002);
    wait_out(d, lat);
    chk("ovf_data", d, 9'h000);
    tick();
    send(9'h000, 9'h0ff, 9'h1ff);
    wait_out(d, lat);
    chk("zero_data", d, 9'h000);
    tick();

    bus.mode = 1'b1;
    send(9'd200, 9'd100, 9'd10);
    wait_out(d, lat);
    chk("sum_data", d, 9'h136);
    tick();
    bus.mode = 1'b0;

    // skew: channel 0 runs two items ahead
    bus.s_valid = 3'b001;
    bus.s_data  = {9'd0, 9'd0, 9'd2};
    tick();
    chk("skew_ready0_1", bus.s_ready[0], 1);
    bus.s_data = {9'd0, 9'd0, 9'd3};
    tick();
    chk("skew_ready0_2", bus.s_ready[0], 0);
    bus.s_valid = '0;
    tick();
    tick();
    chk("skew_no_result", bus.m_valid, 0);
    bus.s_valid = 3'b110;
    bus.s_data  = {9'd6, 9'd4, 9'd0};
    tick();
    bus.s_data  = {9'd7, 9'd5, 9'd0};
    tick();
    bus.s_valid = '0;
    wait_out(d, lat);
    chk("skew_res1", d, 9'h130);
    tick();
    wait_out(d, lat);
    chk("skew_res2", d, 9'h169);
    chk("skew_no_bubble", lat, 0);
    tick();

    // back-pressure with fresh counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < CHL; i++) acc_cnt[i] = 0;
    for (int k = 1; k <= 8; k++) begin
      bus.s_data  = {9'd2, 9'd1, 9'(k)};
      bus.s_valid = '1;
      for (int i = 0; i < CHL; i++) acc_cnt[i] += int'(bus.s_ready[i]);
      tick();
    end
    bus.s_valid = '0;
    for (int i = 0; i < CHL; i++) chk($sformatf("bp_accepted_ch%0d", i), acc_cnt[i], 2 + DEPTH);
    chk("bp_s_ready", bus.s_ready, 3'b000);
    chk("bp_m_valid", bus.m_valid, 1);
    chk("bp_m_data", bus.m_data, 9'h102);
    tick();
    tick();
    tick();
    chk("bp_m_data_hold", bus.m_data, 9'h102);
    bus.m_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("bp_out%0d_valid", j), bus.m_valid, 1);
      chk($sformatf("bp_out%0d_data", j), bus.m_data, 9'h100 | 9'(2 * (j + 1)));
      tick();
    end
    chk("bp_drained", bus.m_valid, 0);
    chk("bp_txn_cnt", bus.txn_cnt, 4);
    chk("bp_s_ready_back", bus.s_ready, 3'b111);

    // reset with three items in flight
    bus.m_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send(9'(k), 9'd1, 9'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_txn_cnt", bus.txn_cnt, 0);
    chk("mid_rst_s_ready", bus.s_ready, 3'b111);
    chk("mid_rst_m_data", bus.m_data, 0);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("mid_rst_no_stale", bus.m_valid, 0);
    bus.mode = 1'b1;
    send(9'd1, 9'd2, 9'd3);
    wait_out(d, lat);
    chk("post_rst_data", d, 9'h106);
    tick();
    chk("post_rst_txn_cnt", bus.txn_cnt, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
